// File: rtl/seq_detector_param.sv
// Parameterised N-bit serial pattern detector (Moore) with overlap control and a
// saturating match counter. Define SEQDET_TIMEOUT_EN to add the idle-timeout state reset.
module seq_detector_param #(
  parameter int             N       = 2,
  parameter logic [N-1:0]   PATTERN = 'b01,
  parameter int             CNT_W   = 8,
  parameter int             TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             A,
  input  logic             in_valid,
  input  logic             overlap,
  input  logic             cnt_clr,
  output logic             y,
  output logic [CNT_W-1:0] match_count
);

  localparam int SW  = $clog2(N + 1);
  localparam int TAB = 1 << SW;

  localparam logic [SW-1:0] S_IDLE = '0;
  localparam logic [SW-1:0] S_FULL = SW'(N);

  if (N < 2 || N > 16 || TIMEOUT < 1) begin : g_bad_param
    $error("seq_detector_param: N must be 2..16 and TIMEOUT >= 1");
  end

  // Longest prefix of PATTERN that is a suffix of (first k pattern bits, then b).
  // Evaluated only at elaboration to fill the transition tables.
  function automatic int kmp_next(input int k, input logic b);
    int pat;
    int s;
    int best;
    pat  = int'(PATTERN);
    s    = ((pat >> (N - k)) << 1) | 32'(b);
    best = 0;
    for (int l = 1; l <= N; l++) begin
      if (l <= k + 1 && (s & ((1 << l) - 1)) == (pat >> (N - l)))
        best = l;
    end
    return best;
  endfunction

  logic [SW-1:0] next_on0 [TAB];
  logic [SW-1:0] next_on1 [TAB];

  for (genvar k = 0; k < TAB; k++) begin : g_tab
    if (k <= N) begin : g_live
      localparam int NX0 = kmp_next(k, 1'b0);
      localparam int NX1 = kmp_next(k, 1'b1);
      assign next_on0[k] = SW'(NX0);
      assign next_on1[k] = SW'(NX1);
    end else begin : g_pad
      assign next_on0[k] = S_IDLE;
      assign next_on1[k] = S_IDLE;
    end
  end

  logic [SW-1:0] state;
  logic [SW-1:0] base_state;
  logic [SW-1:0] state_next;
  logic          match_hit;
  logic          timeout_hit;

`ifdef SEQDET_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT + 1);
  logic [IW-1:0] idle_cnt;

  assign timeout_hit = (idle_cnt == IW'(TIMEOUT));

  // Idle counter saturates at TIMEOUT and keeps the state pinned to 0 until data returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      idle_cnt <= '0;
    else if (in_valid)
      idle_cnt <= '0;
    else if (!timeout_hit)
      idle_cnt <= idle_cnt + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Row N of the table is the overlapping continuation; non-overlap restarts from row 0.
  always_comb begin
    base_state = state;
    if (timeout_hit || (state == S_FULL && !overlap))
      base_state = S_IDLE;
    state_next = timeout_hit ? S_IDLE : state;
    if (in_valid)
      state_next = A ? next_on1[base_state] : next_on0[base_state];
  end

  assign match_hit = in_valid && (state_next == S_FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      y     <= 1'b0;
    end else begin
      state <= state_next;
      y     <= (state_next == S_FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      match_count <= '0;
    else if (cnt_clr)
      match_count <= '0;
    else if (match_hit && match_count != {CNT_W{1'b1}})
      match_count <= match_count + 1'b1;
  end

endmodule
